local_bus_sequencer: RTL and testbench



---
 rtl/local_bus_sequencer.sv | 167 ++++++++++++++++
 tb/tb_local_bus_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_bus_sequencer.sv
// Local-bus ownership sequencer for the A4092: arbitrates between Zorro III slave
// accesses and 53C710 DMA mastership, with turnaround, grant timeout and tenure watch.
module local_bus_sequencer #(
  parameter int unsigned TURN_CYCLES    = 2,
  parameter int unsigned GRANT_TIMEOUT  = 255,
  parameter int unsigned BACKOFF_CYCLES = 16,
  parameter int unsigned MAX_TENURE     = 4095
) (
  input  logic CLK,
  input  logic RESET,
  input  logic slave_req,
  input  logic slave_done,
  input  logic SBR_n,
  input  logic zbus_grant,
  input  logic status_clr,
  output logic zbus_req,
  output logic slave_gnt,
  output logic SBG_n,
  output logic MASTER_n,
  output logic busy,
  output logic grant_timeout,
  output logic tenure_overrun,
  output logic bus_lost
);

  localparam int unsigned MaxA     = (TURN_CYCLES > GRANT_TIMEOUT) ? TURN_CYCLES : GRANT_TIMEOUT;
  localparam int unsigned MaxB     = (BACKOFF_CYCLES > MAX_TENURE) ? BACKOFF_CYCLES : MAX_TENURE;
  localparam int unsigned MaxParam = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW     = $clog2(MaxParam + 1);

  localparam logic [CntW-1:0] TurnLast = CntW'(TURN_CYCLES - 1);
  localparam logic [CntW-1:0] GtoLast  = CntW'(GRANT_TIMEOUT - 1);
  localparam logic [CntW-1:0] BackLast = CntW'(BACKOFF_CYCLES - 1);
  localparam logic [CntW-1:0] TenLast  = CntW'(MAX_TENURE - 1);

  typedef enum logic [2:0] {
    StIdle, StSlave, StTurnOut, StZreq, StBackoff, StTurnIn, StDma, StRelease
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_sync1;
  logic            r_sync2;
  logic            w_sbr;
  logic            w_set_gto;
  logic            w_set_ovr;
  logic            w_set_lost;
  logic            r_zbus_req;
  logic            r_slave_gnt;
  logic            r_sbg_n;
  logic            r_master_n;
  logic            r_busy;
  logic            r_gto;
  logic            r_ovr;
  logic            r_lost;

  assign w_sbr = ~r_sync2;

  always_comb begin
    w_state_d  = r_state;
    w_set_gto  = 1'b0;
    w_set_ovr  = 1'b0;
    w_set_lost = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (slave_req) begin
          w_state_d = StSlave;
        end else if (w_sbr) begin
          w_state_d = StZreq;
        end
      end
      StSlave: begin
        if (slave_done || !slave_req) w_state_d = StTurnOut;
      end
      StTurnOut: begin
        if (r_cnt == TurnLast) w_state_d = StIdle;
      end
      StZreq: begin
        // Slave service wins so a host access can never deadlock behind a pending DMA grant.
        if (slave_req) begin
          w_state_d = StSlave;
        end else if (!w_sbr) begin
          w_state_d = StIdle;
        end else if (zbus_grant) begin
          w_state_d = StTurnIn;
        end else if (r_cnt == GtoLast) begin
          w_set_gto = 1'b1;
          w_state_d = StBackoff;
        end
      end
      StBackoff: begin
        if (r_cnt == BackLast) w_state_d = StIdle;
      end
      StTurnIn: begin
        if (r_cnt == TurnLast) w_state_d = StDma;
      end
      StDma: begin
        if (r_cnt == TenLast) w_set_ovr = 1'b1;
        if (!w_sbr) begin
          w_state_d = StRelease;
        end else if (!zbus_grant) begin
          w_set_lost = 1'b1;
          w_state_d  = StRelease;
        end
      end
      StRelease: begin
        if (r_cnt == TurnLast) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // One shared saturating counter, cleared on every state change.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_state_d != r_state) begin
      w_cnt_d = '0;
    end else if (!(&r_cnt)) begin
      w_cnt_d = r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_zbus_req  <= 1'b0;
      r_slave_gnt <= 1'b0;
      r_sbg_n     <= 1'b1;
      r_master_n  <= 1'b1;
      r_busy      <= 1'b0;
      r_gto       <= 1'b0;
      r_ovr       <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_sync1     <= SBR_n;
      r_sync2     <= r_sync1;
      // Outputs are decoded from the next state so they line up with r_state.
      r_zbus_req  <= (w_state_d == StZreq) || (w_state_d == StTurnIn) ||
                     (w_state_d == StDma) || (w_state_d == StRelease);
      r_slave_gnt <= (w_state_d == StSlave);
      r_sbg_n     <= (w_state_d != StDma);
      r_master_n  <= !((w_state_d == StTurnIn) || (w_state_d == StDma) ||
                       (w_state_d == StRelease));
      r_busy      <= (w_state_d != StIdle);
      r_gto       <= w_set_gto  | (r_gto  & ~status_clr);
      r_ovr       <= w_set_ovr  | (r_ovr  & ~status_clr);
      r_lost      <= w_set_lost | (r_lost & ~status_clr);
    end
  end

  assign zbus_req       = r_zbus_req;
  assign slave_gnt      = r_slave_gnt;
  assign SBG_n          = r_sbg_n;
  assign MASTER_n       = r_master_n;
  assign busy           = r_busy;
  assign grant_timeout  = r_gto;
  assign tenure_overrun = r_ovr;
  assign bus_lost       = r_lost;

endmodule

// File: tb/tb_local_bus_sequencer.sv
// Bench for local_bus_sequencer: directed scenarios with literal checks, then random
// traffic, all compared every cycle against a phase/countdown model of the sequencer.
module tb_local_bus_sequencer;

  localparam int unsigned TC = 2;
  localparam int unsigned GT = 8;
  localparam int unsigned BC = 4;
  localparam int unsigned MT = 20;

  localparam int PIdle = 0, PSlave = 1, PTurnOut = 2, PZreq = 3;
  localparam int PBackoff = 4, PTurnIn = 5, PDma = 6, PRel = 7;

  logic CLK = 1'b0;
  logic RESET, slave_req, slave_done, SBR_n, zbus_grant, status_clr;
  logic zbus_req, slave_gnt, SBG_n, MASTER_n, busy;
  logic grant_timeout, tenure_overrun, bus_lost;

  int checks = 0;
  int errors = 0;

  int m_ph = PIdle;
  int m_rem = 0;
  int m_wait = 0;
  int m_ten = 0;
  bit m_s1 = 1'b1, m_s2 = 1'b1;
  bit m_gto = 1'b0, m_ovr = 1'b0, m_lost = 1'b0;

  local_bus_sequencer #(
    .TURN_CYCLES   (TC),
    .GRANT_TIMEOUT (GT),
    .BACKOFF_CYCLES(BC),
    .MAX_TENURE    (MT)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .slave_req     (slave_req),
    .slave_done    (slave_done),
    .SBR_n         (SBR_n),
    .zbus_grant    (zbus_grant),
    .status_clr    (status_clr),
    .zbus_req      (zbus_req),
    .slave_gnt     (slave_gnt),
    .SBG_n         (SBG_n),
    .MASTER_n      (MASTER_n),
    .busy          (busy),
    .grant_timeout (grant_timeout),
    .tenure_overrun(tenure_overrun),
    .bus_lost      (bus_lost)
  );

  always #5 CLK = ~CLK;

  // Advance the model by one clock using the inputs the DUT sampled on this edge.
  task automatic model_step();
    bit sbr, sg, so, sl;
    if (RESET) begin
      m_ph = PIdle; m_rem = 0; m_wait = 0; m_ten = 0;
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_gto = 1'b0; m_ovr = 1'b0; m_lost = 1'b0;
    end else begin
      sbr = !m_s2;
      m_s2 = m_s1;
      m_s1 = SBR_n;
      sg = 1'b0; so = 1'b0; sl = 1'b0;
      case (m_ph)
        PIdle: begin
          if (slave_req) m_ph = PSlave;
          else if (sbr) begin m_ph = PZreq; m_wait = 0; end
        end
        PSlave: if (slave_done || !slave_req) begin m_ph = PTurnOut; m_rem = TC; end
        PTurnOut: begin m_rem--; if (m_rem == 0) m_ph = PIdle; end
        PZreq: begin
          m_wait++;
          if (slave_req) m_ph = PSlave;
          else if (!sbr) m_ph = PIdle;
          else if (zbus_grant) begin m_ph = PTurnIn; m_rem = TC; end
          else if (m_wait == GT) begin sg = 1'b1; m_ph = PBackoff; m_rem = BC; end
        end
        PBackoff: begin m_rem--; if (m_rem == 0) m_ph = PIdle; end
        PTurnIn: begin m_rem--; if (m_rem == 0) begin m_ph = PDma; m_ten = 0; end end
        PDma: begin
          if (m_ten < MT) begin m_ten++; if (m_ten == MT) so = 1'b1; end
          if (!sbr) begin m_ph = PRel; m_rem = TC; end
          else if (!zbus_grant) begin sl = 1'b1; m_ph = PRel; m_rem = TC; end
        end
        PRel: begin m_rem--; if (m_rem == 0) m_ph = PIdle; end
        default: m_ph = PIdle;
      endcase
      m_gto  = sg | (m_gto  & !status_clr);
      m_ovr  = so | (m_ovr  & !status_clr);
      m_lost = sl | (m_lost & !status_clr);
    end
  endtask

  function automatic logic exp_zreq();
    return m_ph inside {PZreq, PTurnIn, PDma, PRel};
  endfunction

  task automatic check1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_all();
    check1("zbus_req", zbus_req, exp_zreq());
    check1("slave_gnt", slave_gnt, m_ph == PSlave);
    check1("SBG_n", SBG_n, m_ph != PDma);
    check1("MASTER_n", MASTER_n, !(m_ph inside {PTurnIn, PDma, PRel}));
    check1("busy", busy, m_ph != PIdle);
    check1("grant_timeout", grant_timeout, m_gto);
    check1("tenure_overrun", tenure_overrun, m_ovr);
    check1("bus_lost", bus_lost, m_lost);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RESET = 1'b1; slave_req = 1'b0; slave_done = 1'b0; SBR_n = 1'b1;
    zbus_grant = 1'b0; status_clr = 1'b0;
    @(negedge CLK);
    ticks(2);
    check1("lit_reset_SBG_n", SBG_n, 1'b1);
    check1("lit_reset_MASTER_n", MASTER_n, 1'b1);
    check1("lit_reset_busy", busy, 1'b0);
    RESET = 1'b0;
    ticks(2);

    // Slave only
    slave_req = 1'b1;
    tick();
    check1("lit_slave_gnt_c1", slave_gnt, 1'b1);
    ticks(4);
    slave_done = 1'b1; slave_req = 1'b0;
    tick();
    check1("lit_slave_gnt_c6", slave_gnt, 1'b0);
    slave_done = 1'b0;
    tick();
    check1("lit_busy_c7", busy, 1'b1);
    tick();
    check1("lit_busy_c8", busy, 1'b0);
    ticks(2);

    // DMA
    SBR_n = 1'b0;
    ticks(2);
    check1("lit_zreq_t2", zbus_req, 1'b0);
    tick();
    check1("lit_zreq_t3", zbus_req, 1'b1);
    ticks(3);
    zbus_grant = 1'b1;
    tick();
    check1("lit_turnin_MASTER_n", MASTER_n, 1'b0);
    check1("lit_turnin_SBG_n", SBG_n, 1'b1);
    ticks(2);
    check1("lit_dma_SBG_n", SBG_n, 1'b0);
    ticks(4);
    SBR_n = 1'b1;
    ticks(2);
    check1("lit_dma_hold_SBG_n", SBG_n, 1'b0);
    tick();
    check1("lit_release_SBG_n", SBG_n, 1'b1);
    check1("lit_release_MASTER_n", MASTER_n, 1'b0);
    ticks(2);
    check1("lit_idle_MASTER_n", MASTER_n, 1'b1);
    check1("lit_idle_zreq", zbus_req, 1'b0);
    zbus_grant = 1'b0;
    ticks(3);

    // Contention, then grant timeout with backoff
    slave_req = 1'b1; SBR_n = 1'b0;
    tick();
    check1("lit_contention_slave_first", slave_gnt, 1'b1);
    check1("lit_contention_no_zreq", zbus_req, 1'b0);
    ticks(2);
    slave_done = 1'b1; slave_req = 1'b0;
    tick();
    slave_done = 1'b0;
    ticks(3);
    check1("lit_retry_zreq", zbus_req, 1'b1);
    ticks(7);
    check1("lit_gto_not_yet", grant_timeout, 1'b0);
    tick();
    check1("lit_gto_set", grant_timeout, 1'b1);
    check1("lit_backoff_zreq", zbus_req, 1'b0);
    ticks(4);
    check1("lit_backoff_idle_zreq", zbus_req, 1'b0);
    tick();
    check1("lit_rerequest_zreq", zbus_req, 1'b1);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    check1("lit_gto_cleared", grant_timeout, 1'b0);
    SBR_n = 1'b1;
    ticks(5);

    // Tenure overrun then bus loss
    SBR_n = 1'b0;
    ticks(3);
    zbus_grant = 1'b1;
    ticks(3);
    ticks(30);
    check1("lit_overrun", tenure_overrun, 1'b1);
    check1("lit_overrun_SBG_n", SBG_n, 1'b0);
    zbus_grant = 1'b0;
    tick();
    check1("lit_bus_lost", bus_lost, 1'b1);
    check1("lit_lost_SBG_n", SBG_n, 1'b1);
    check1("lit_lost_MASTER_n", MASTER_n, 1'b0);
    ticks(2);
    check1("lit_lost_idle_MASTER_n", MASTER_n, 1'b1);

    // Reset mid-DMA
    tick();
    zbus_grant = 1'b1;
    ticks(4);
    check1("lit_predreset_SBG_n", SBG_n, 1'b0);
    RESET = 1'b1;
    tick();
    check1("lit_rst_MASTER_n", MASTER_n, 1'b1);
    check1("lit_rst_SBG_n", SBG_n, 1'b1);
    check1("lit_rst_zreq", zbus_req, 1'b0);
    check1("lit_rst_overrun", tenure_overrun, 1'b0);
    check1("lit_rst_lost", bus_lost, 1'b0);
    check1("lit_rst_busy", busy, 1'b0);
    RESET = 1'b0; SBR_n = 1'b1; zbus_grant = 1'b0;
    ticks(3);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if (slave_done) begin
        slave_done = 1'b0; slave_req = 1'b0;
      end else if (slave_req && ($urandom % 6 == 0)) begin
        slave_done = 1'b1;
      end else if (slave_req && ($urandom % 40 == 0)) begin
        slave_req = 1'b0;
      end else if (!slave_req && ($urandom % 20 == 0)) begin
        slave_req = 1'b1;
      end
      if ($urandom % 30 == 0) SBR_n = ~SBR_n;
      if (!exp_zreq()) zbus_grant = 1'b0;
      else if (!zbus_grant && ($urandom % 3 == 0)) zbus_grant = 1'b1;
      else if (zbus_grant && ($urandom % 50 == 0)) zbus_grant = 1'b0;
      status_clr = ($urandom % 25 == 0);
      RESET = ($urandom % 500 == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
